// File: rtl/jpeg_ff_pkg.sv
// Shared constants and types for the JPEG 0xFF byte-stuffing stage.
// Field offsets describe the 91-bit entry written into the output FIFO.
package jpeg_ff_pkg;

    localparam int EOF_BIT = 64;
    localparam int CNT_LSB = 65;
    localparam int W0_MSB  = 63;
    localparam int W1_MSB  = 31;

    localparam logic [7:0] BYTE_FF = 8'hFF;
    localparam logic [7:0] STUFF   = 8'h00;

    typedef enum logic {
        RUN,
        FLUSH
    } state_e;

endpackage

// File: rtl/jpeg_ff_stuffer_expander.sv
// Combinational expansion of up to four bytes, inserting 0x00 after 0xFF.
// Output is left-aligned; unused trailing bytes are zero.
module ff_byte_expander
    import jpeg_ff_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [2:0]  nvalid_i,
    output logic [63:0] exp_o,
    output logic [3:0]  len_o,
    output logic [2:0]  nff_o
);

    logic [7:0] ob [8];
    logic [3:0] len;
    logic [2:0] nff;

    // Walk the valid bytes in stream order and append each expansion
    always_comb begin
        for (int k = 0; k < 8; k++) ob[k] = STUFF;
        len = '0;
        nff = '0;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < nvalid_i) begin
                ob[len[2:0]] = word_i[31-8*i -: 8];
                len = len + 4'd1;
                if (word_i[31-8*i -: 8] == BYTE_FF) begin
                    ob[len[2:0]] = STUFF;
                    len = len + 4'd1;
                    nff = nff + 3'd1;
                end
            end
        end
    end

    assign exp_o = {ob[0], ob[1], ob[2], ob[3],
                    ob[4], ob[5], ob[6], ob[7]};
    assign len_o = len;
    assign nff_o = nff;

endmodule

// File: rtl/jpeg_ff_stuffer.sv
// JPEG byte-stuffing stage: expands 0xFF bytes and repacks into 32-bit words.
// Writes one FIFO entry per accepted word, plus a flush entry on eof overflow.
module jpeg_ff_stuffer
    import jpeg_ff_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic        data_in_valid,
    input  logic        eof_in,
    input  logic [1:0]  eof_bytes,
    output logic        in_ready,
    output logic [90:0] fifo_wdata,
    output logic        fifo_we,
    output logic        fifo_rollover
);

    state_e      state_q, state_d;
    logic [23:0] hold_q, hold_d;
    logic [1:0]  hcnt_q, hcnt_d;
    logic [90:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        roll_q, roll_d;

    logic [2:0]  nvalid;
    logic [63:0] exp_bytes;
    logic [3:0]  exp_len;
    logic [2:0]  exp_nff;
    logic [1:0]  hgap;
    logic [87:0] stream;
    logic [3:0]  tot;
    logic [31:0] w0, w1;
    logic        two;

    assign nvalid = !eof_in ? 3'd4 :
                    (eof_bytes == 2'd0) ? 3'd4 : {1'b0, eof_bytes};

    ff_byte_expander u_exp (
        .word_i   (data_in),
        .nvalid_i (nvalid),
        .exp_o    (exp_bytes),
        .len_o    (exp_len),
        .nff_o    (exp_nff)
    );

    // Hold bytes first, expansion appended right after them
    assign hgap   = 2'd3 - hcnt_q;
    assign stream = {hold_q, 64'd0}
                  | ({24'd0, exp_bytes} << {hgap, 3'b000});
    assign tot    = {2'b00, hcnt_q} + exp_len;
    assign w0     = stream[87:56];
    assign w1     = stream[55:24];
    assign two    = ({1'b0, hcnt_q} + exp_nff) >= 3'd4;

    assign in_ready      = (state_q == RUN);
    assign fifo_wdata    = wdata_q;
    assign fifo_we       = we_q;
    assign fifo_rollover = roll_q;

    // Next-state: word packing, hold update and RUN/FLUSH sequencing
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        hcnt_d  = hcnt_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        roll_d  = 1'b0;
        unique case (state_q)
            RUN: begin
                if (data_in_valid) begin
                    we_d    = 1'b1;
                    wdata_d = '0;
                    wdata_d[W0_MSB -: 32] = w0;
                    if (!eof_in) begin
                        roll_d = two;
                        if (two) wdata_d[W1_MSB -: 32] = w1;
                        hold_d = two ? stream[23:0] : stream[55:32];
                        hcnt_d = tot[1:0];
                    end else if (tot <= 4'd4) begin
                        wdata_d[EOF_BIT]      = 1'b1;
                        wdata_d[CNT_LSB +: 3] = tot[2:0];
                        hold_d = '0;
                        hcnt_d = '0;
                    end else if (tot <= 4'd8) begin
                        roll_d = 1'b1;
                        wdata_d[W1_MSB -: 32] = w1;
                        wdata_d[EOF_BIT]      = 1'b1;
                        wdata_d[CNT_LSB +: 3] = tot[2:0] - 3'd4;
                        hold_d = '0;
                        hcnt_d = '0;
                    end else begin
                        roll_d = 1'b1;
                        wdata_d[W1_MSB -: 32] = w1;
                        hold_d  = stream[23:0];
                        hcnt_d  = tot[1:0];
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                we_d    = 1'b1;
                wdata_d = '0;
                wdata_d[W0_MSB -: 32] = {hold_q, STUFF};
                wdata_d[EOF_BIT]      = 1'b1;
                wdata_d[CNT_LSB +: 3] = {1'b0, hcnt_q};
                hold_d  = '0;
                hcnt_d  = '0;
                state_d = RUN;
            end
        endcase
    end

    // State, hold and registered FIFO write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            hold_q  <= '0;
            hcnt_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            roll_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            hcnt_q  <= hcnt_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            roll_q  <= roll_d;
        end
    end

endmodule

// File: tb/tb_jpeg_ff_stuffer.sv
// Testbench for jpeg_ff_stuffer: directed cases plus random words checked
// against a byte-queue model of the stuffed stream.
module tb_jpeg_ff_stuffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_in;
    logic        data_in_valid;
    logic        eof_in;
    logic [1:0]  eof_bytes;
    logic        in_ready;
    logic [90:0] fifo_wdata;
    logic        fifo_we;
    logic        fifo_rollover;

    int compared = 0;
    int mismatched = 0;

    byte unsigned hq[$];
    logic [90:0]  ent1, ent2;
    logic         ir_fl;

    jpeg_ff_stuffer dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .eof_in        (eof_in),
        .eof_bytes     (eof_bytes),
        .in_ready      (in_ready),
        .fifo_wdata    (fifo_wdata),
        .fifo_we       (fifo_we),
        .fifo_rollover (fifo_rollover)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [90:0] obs, logic [90:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [90:0] mk(logic [31:0] w0, logic [31:0] w1,
                                       bit eof, int cnt);
        logic [2:0] c;
        c = 3'(cnt);
        return {23'd0, c, eof, w0, w1};
    endfunction

    task automatic send(logic [31:0] d, bit eof, logic [1:0] eb,
                        bit rst_in_flush, string tag);
        byte unsigned s[$];
        byte unsigned b;
        int n, t, keep;
        bit fl, ro;
        logic [31:0] w0, w1, hw;
        logic [90:0] e, obs;
        fl = 0;
        s = hq;
        n = !eof ? 4 : (eb == 0 ? 4 : int'(eb));
        for (int i = 0; i < n; i++) begin
            b = d[31-8*i -: 8];
            s.push_back(b);
            if (b == 8'hFF) s.push_back(8'h00);
        end
        t = s.size();
        while (s.size() < 12) s.push_back(8'h00);
        w0 = {s[0], s[1], s[2], s[3]};
        w1 = {s[4], s[5], s[6], s[7]};
        keep = 0;
        if (!eof) begin
            ro = (t >= 8);
            e = mk(w0, ro ? w1 : 32'd0, 0, 0);
            keep = ro ? 8 : 4;
        end else if (t <= 4) begin
            ro = 0;
            e = mk(w0, 32'd0, 1, t);
        end else if (t <= 8) begin
            ro = 1;
            e = mk(w0, w1, 1, t - 4);
        end else begin
            ro = 1;
            fl = 1;
            e = mk(w0, w1, 0, 0);
            keep = 8;
        end
        hq.delete();
        if (keep != 0)
            for (int i = keep; i < t; i++) hq.push_back(s[i]);

        @(negedge clk);
        data_in = d;
        data_in_valid = 1'b1;
        eof_in = eof;
        eof_bytes = eb;
        @(posedge clk);
        #1;
        data_in_valid = 1'b0;
        eof_in = 1'b0;
        obs = fifo_wdata;
        if (!ro) obs[31:0] = 32'd0;
        ent1 = obs;
        chk({tag, ".we"}, fifo_we, 1'b1);
        chk({tag, ".roll"}, fifo_rollover, ro);
        chk({tag, ".entry"}, obs, e);
        chk({tag, ".rdy"}, in_ready, !fl);
        ir_fl = in_ready;
        if (!fl) return;

        if (rst_in_flush) begin
            rst = 1'b1;
            #1;
            chk({tag, ".rst_we"}, fifo_we, 1'b0);
            chk({tag, ".rst_roll"}, fifo_rollover, 1'b0);
            chk({tag, ".rst_data"}, fifo_wdata, 91'd0);
            chk({tag, ".rst_rdy"}, in_ready, 1'b1);
            hq.delete();
            @(negedge clk);
            rst = 1'b0;
            return;
        end

        hw = 32'd0;
        for (int i = 0; i < hq.size(); i++) hw[31-8*i -: 8] = hq[i];
        e = mk(hw, 32'd0, 1, hq.size());
        hq.delete();
        // Stalled upstream word must not be absorbed during the flush
        data_in = $urandom;
        data_in_valid = 1'b1;
        @(posedge clk);
        #1;
        data_in_valid = 1'b0;
        obs = fifo_wdata;
        obs[31:0] = 32'd0;
        ent2 = obs;
        chk({tag, ".fl_we"}, fifo_we, 1'b1);
        chk({tag, ".fl_roll"}, fifo_rollover, 1'b0);
        chk({tag, ".fl_entry"}, obs, e);
        chk({tag, ".fl_rdy"}, in_ready, 1'b1);
    endtask

    task automatic idle(string tag);
        @(negedge clk);
        data_in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, ".idle_we"}, fifo_we, 1'b0);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        for (int i = 0; i < 4; i++)
            w[8*i +: 8] = ($urandom_range(0, 2) == 0) ? 8'hFF
                                                       : 8'($urandom);
        return w;
    endfunction

    initial begin
        rst = 1'b1;
        data_in = '0;
        data_in_valid = 1'b0;
        eof_in = 1'b0;
        eof_bytes = '0;
        #1;
        chk("reset.we", fifo_we, 1'b0);
        chk("reset.roll", fifo_rollover, 1'b0);
        chk("reset.data", fifo_wdata, 91'd0);
        chk("reset.rdy", in_ready, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("post_reset.rdy", in_ready, 1'b1);

        send(32'h12345678, 0, 2'd0, 0, "plain");
        chk("plain.w0", ent1[63:32], 32'h12345678);
        send(32'hFFFFFFFF, 0, 2'd0, 0, "allff");
        chk("allff.w01", ent1[63:0], 64'hFF00FF00FF00FF00);
        send(32'hAAFF0000, 1, 2'd2, 0, "eof2");
        chk("eof2.w0", ent1[63:32], 32'hAAFF0000);
        chk("eof2.cnt", ent1[67:64], 4'b0111);
        send(32'hFF00AB01, 0, 2'd0, 0, "mix1");
        chk("mix1.w0", ent1[63:32], 32'hFF0000AB);
        send(32'h11223344, 0, 2'd0, 0, "mix2");
        chk("mix2.w0", ent1[63:32], 32'h01112233);
        idle("gap");
        send(32'h55000000, 1, 2'd1, 0, "eof1");
        chk("eof1.w0", ent1[63:32], 32'h44550000);
        send(32'hFFFF1122, 0, 2'd0, 0, "pre1");
        send(32'hFFA1B2C3, 0, 2'd0, 0, "pre2");
        chk("pre2.w0", ent1[63:32], 32'h1122FF00);
        send(32'hFFFFFFFF, 1, 2'd0, 0, "ovf");
        chk("ovf.e1", ent1[67:0], {4'b0000, 64'hA1B2C3FF00FF00FF});
        chk("ovf.rdy_low", ir_fl, 1'b0);
        chk("ovf.e2", ent2[67:32], {4'b0111, 32'h00FF0000});

        send(32'hFFFF1122, 0, 2'd0, 0, "rpre");
        send(32'hFFFFFF33, 1, 2'd0, 1, "rflush");
        send(32'h01020304, 0, 2'd0, 0, "after_rst");
        chk("after_rst.w0", ent1[63:32], 32'h01020304);

        for (int k = 0; k < 400; k++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) idle("rnd");
            else if (r == 1)
                send(rand_word(), 1, 2'($urandom), 0, "rnd_eof");
            else
                send(rand_word(), 0, 2'd0, 0, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
